// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the pooling-engine arbiter
//
// Contents:
//   DEF_N_REQ       default number of requesters sharing the pooling engine
//   DEF_TIMEOUT_CYC default engine watchdog limit in clk cycles
//   arb_state_e     arbiter state encoding (IDLE, START, BUSY, RELEASE)

package cnn_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pool_arbiter_rr_picker.sv
// rtl/pool_arbiter_rr_picker.sv - combinational round-robin picker (module rr_picker)
//
// Ports:
//   req    in  N_REQ          request vector
//   rr_ptr in  $clog2(N_REQ)  index searched first; search rotates upward and wraps
//   grant  out N_REQ          one-hot winner, zero when no request
//   idx    out $clog2(N_REQ)  binary index of the winner
//   valid  out 1              at least one request present

module rr_picker #(
  parameter int N_REQ = cnn_pkg::DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;
    grant    = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Walk N_REQ candidates starting at rr_ptr; the first hit wins.
    // The wrap is done in int arithmetic so non-power-of-two N_REQ works.
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_arbiter.sv
// rtl/pool_arbiter.sv - round-robin arbiter granting one pooling engine to N_REQ cores
//
// Ports:
//   clk         in  1              clock, rising edge
//   rst         in  1              synchronous active-high reset
//   req         in  N_REQ          level requests, held until the matching done_o
//   grant       out N_REQ          one-hot engine ownership, zero when idle
//   sel         out $clog2(N_REQ)  binary index of the owner (input/output-map mux)
//   eng_start   out 1              one-cycle engine start pulse
//   eng_done    in  1              engine completion pulse
//   done_o      out N_REQ          one-cycle completion pulse to the owner
//   timeout_err out 1              one-cycle watchdog-abort pulse
//
// Build option: define POOL_ARB_TIMEOUT_EN to build the BUSY watchdog
// (limit TIMEOUT_CYC). Without it timeout_err is tied low and BUSY waits
// for eng_done indefinitely.

module pool_arbiter
  import cnn_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     eng_start,
  input  logic                     eng_done,
  output logic [N_REQ-1:0]         done_o,
  output logic                     timeout_err
);

  localparam int               SEL_W    = $clog2(N_REQ);
  localparam int               WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REQ - 1);

  arb_state_e       state, state_d;
  logic [N_REQ-1:0] grant_d;
  logic [N_REQ-1:0] done_d;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_d;
  logic             eng_start_d;

  logic [N_REQ-1:0] pick_grant;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

`ifdef POOL_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  logic            timeout_q, timeout_d;

  assign timeout_err = timeout_q;
`else
  // Keeps TIMEOUT_CYC referenced in builds without the watchdog.
  logic [WD_W-1:0] wd_limit_unused;

  assign wd_limit_unused = WD_W'(TIMEOUT_CYC);
  assign timeout_err     = 1'b0;
`endif

  // All outputs are registered: grant/sel appear the cycle after IDLE
  // arbitrates, eng_start the cycle after START, done_o the cycle after
  // eng_done is seen in BUSY (that cycle is RELEASE).
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    sel_d       = sel;
    rr_ptr_d    = rr_ptr;
    eng_start_d = 1'b0;
    done_d      = '0;
`ifdef POOL_ARB_TIMEOUT_EN
    wd_cnt_d    = wd_cnt;
    timeout_d   = 1'b0;
`endif

    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          sel_d   = pick_idx;
          state_d = ST_START;
        end else begin
          grant_d = '0;
        end
      end

      ST_START: begin
        eng_start_d = 1'b1;
        state_d     = ST_BUSY;
`ifdef POOL_ARB_TIMEOUT_EN
        wd_cnt_d    = '0;
`endif
      end

      ST_BUSY: begin
`ifdef POOL_ARB_TIMEOUT_EN
        wd_cnt_d = wd_cnt + 1'b1;
`endif
        // eng_done is tested first so a completion in the limit cycle wins.
        if (eng_done) begin
          done_d  = grant;
          state_d = ST_RELEASE;
        end
`ifdef POOL_ARB_TIMEOUT_EN
        else if (wd_cnt == WD_LIMIT) begin
          done_d    = grant;
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end
`endif
      end

      ST_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      eng_start <= 1'b0;
      done_o    <= '0;
`ifdef POOL_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      sel       <= sel_d;
      rr_ptr    <= rr_ptr_d;
      eng_start <= eng_start_d;
      done_o    <= done_d;
`ifdef POOL_ARB_TIMEOUT_EN
      wd_cnt    <= wd_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_pool_arbiter.sv
// tb/tb_pool_arbiter.sv - self-checking bench for pool_arbiter (N_REQ=4, TIMEOUT_CYC=8)

module tb_pool_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       eng_done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       eng_start;
  logic [3:0] done_o;
  logic       timeout_err;

  pool_arbiter #(
    .N_REQ       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .sel         (sel),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .done_o      (done_o),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    int         delay;
  } vec_t;

  vec_t       vecs [11];
  logic [3:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scan();
    logic [3:0] e;
    chk("grant_onehot", {31'b0, $onehot0(grant)}, 32'd1);
    if (eng_start) chk("start_owned", {31'b0, (grant != 4'b0)}, 32'd1);
    if (done_o != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", done_o, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_o", done_o, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    scan();
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == 4'b0 && n < 10);
  endtask

  task automatic run_job(input vec_t v);
    req = v.req;
    exp_q.push_back(v.grant);
    wait_grant();
    chk("grant", grant, v.grant);
    chk("sel", sel, v.sel);
    chk("start_early", eng_start, 0);
    tick();
    chk("eng_start", eng_start, 1);
    for (int k = 0; k < v.delay; k++) begin
      tick();
      chk("grant_hold", grant, v.grant);
      chk("start_once", eng_start, 0);
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("done_seen", exp_q.size(), 0);
    tick();
    chk("idle_grant", grant, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tmo_at;

    vecs[0]  = '{4'b1111, 4'b0001, 2'd0, 0};
    vecs[1]  = '{4'b1111, 4'b0010, 2'd1, 1};
    vecs[2]  = '{4'b1111, 4'b0100, 2'd2, 0};
    vecs[3]  = '{4'b1111, 4'b1000, 2'd3, 2};
    vecs[4]  = '{4'b1111, 4'b0001, 2'd0, 0};
    vecs[5]  = '{4'b0100, 4'b0100, 2'd2, 7};
    vecs[6]  = '{4'b0011, 4'b0001, 2'd0, 1};
    vecs[7]  = '{4'b0011, 4'b0010, 2'd1, 0};
    vecs[8]  = '{4'b1001, 4'b1000, 2'd3, 3};
    vecs[9]  = '{4'b1001, 4'b0001, 2'd0, 0};
    vecs[10] = '{4'b0110, 4'b0010, 2'd1, 1};

    rst      = 1'b1;
    req      = 4'b0;
    eng_done = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_job(vecs[i]);
    end

    // Stray eng_done in IDLE: nothing moves, pointer stays at 2.
    req = 4'b0;
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("stray_grant", grant, 0);
    chk("stray_start", eng_start, 0);
    tick();
    chk("stray_idle", grant, 0);
    run_job('{4'b1110, 4'b0100, 2'd2, 1});

    // Request dropped in BUSY: job still completes.
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant();
    chk("drop_grant", grant, 4'b0010);
    tick();
    chk("drop_start", eng_start, 1);
    req = 4'b0;
    repeat (3) begin
      tick();
      chk("drop_hold", grant, 4'b0010);
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("drop_done_seen", exp_q.size(), 0);
    tick();

`ifdef POOL_ARB_TIMEOUT_EN
    // Watchdog abort 9 cycles after eng_start.
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant();
    chk("wd_grant", grant, 4'b0100);
    tick();
    chk("wd_start", eng_start, 1);
    tmo_at = 0;
    for (int k = 1; k <= 20 && tmo_at == 0; k++) begin
      tick();
      if (timeout_err) tmo_at = k;
    end
    chk("wd_latency", tmo_at, 9);
    chk("wd_done_seen", exp_q.size(), 0);
    tick();
    chk("wd_pulse_width", timeout_err, 0);

    // eng_done in the limit cycle beats the watchdog.
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant();
    chk("race_grant", grant, 4'b0100);
    tick();
    chk("race_start", eng_start, 1);
    repeat (8) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("race_timeout", timeout_err, 0);
    chk("race_done_seen", exp_q.size(), 0);
    tick();
`else
    // No watchdog: BUSY holds until eng_done.
    tmo_at = 0;
    req = 4'b0100;
    wait_grant();
    chk("wd_grant", grant, 4'b0100);
    tick();
    chk("wd_start", eng_start, 1);
    repeat (20) begin
      tick();
      chk("wd_hold", grant, 4'b0100);
      chk("wd_no_timeout", timeout_err, 0);
    end
    exp_q.push_back(4'b0100);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("wd_done_seen", exp_q.size(), 0);
    tick();
`endif

    // Reset mid-job: job abandoned, lowest requester wins afterwards.
    req = 4'b0010;
    wait_grant();
    chk("mid_grant", grant, 4'b0010);
    tick();
    chk("mid_start", eng_start, 1);
    req = 4'b1010;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_start", eng_start, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    rst = 1'b0;
    exp_q.push_back(4'b0010);
    wait_grant();
    chk("post_rst_grant", grant, 4'b0010);
    chk("post_rst_sel", sel, 1);
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("post_rst_done_seen", exp_q.size(), 0);

    req = 4'b0;
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("final_idle", grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
